// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the serial-multiplier product accumulator.
// No logic; compile-time definitions only.
// Imported by the accumulator top and its adder.
package seq_mul_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int PROD_W      = 16;
    localparam int OPND_W      = 8;
    localparam int DEF_ACC_W   = 20;
    localparam int DEF_N_TERMS = 4;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/seq_mul_acc_add.sv
// Signed adder: ACC_W operand plus sign-extended product, with overflow detect.
// Latency: combinational.
// Backpressure: none.
module seq_mul_acc_add
    import seq_mul_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] b_ext;

    // Sign-extend the product, add, and flag a sign flip between like-signed operands
    always_comb begin
        b_ext = ACC_W'($signed(b));
        sum   = a + b_ext;
        ovf   = (a[ACC_W-1] == b_ext[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
    end

endmodule

// File: rtl/seq_mul_acc.sv
// Sums N_TERMS consecutive signed products into one result on a valid/ready port.
// Latency: result valid the cycle after the last product's z_flag.
// Backpressure: one product is parked while the result is stalled; a further one is dropped.
module seq_mul_acc
    import seq_mul_pkg::*;
#(
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [PROD_W-1:0] z,
    input  logic              z_flag,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              ovf,
    output logic              drop,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gov_q, gov_d;
    logic [ACC_W-1:0]    acc_out_q, acc_out_d;
    logic                ovf_q, ovf_d;
    logic                vld_q, vld_d;
    logic [PROD_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                drop_q, drop_d;

    logic [ACC_W-1:0]    pend_ext;
    logic [ACC_W-1:0]    new_base;
    logic [ACC_W-1:0]    sum_acc, sum_new, one_term;
    logic                ovf_acc, ovf_new;

    // Seed for the new-group combine path: parked product if present, else zero
    always_comb begin
        pend_ext = ACC_W'($signed(pend_q));
        new_base = pend_vld_q ? pend_ext : '0;
        one_term = pend_vld_q ? pend_ext : sum_new;
    end

    seq_mul_acc_add #(.ACC_W(ACC_W)) u_add_acc (
        .a   (acc_q),
        .b   (z),
        .sum (sum_acc),
        .ovf (ovf_acc)
    );

    seq_mul_acc_add #(.ACC_W(ACC_W)) u_add_new (
        .a   (new_base),
        .b   (z),
        .sum (sum_new),
        .ovf (ovf_new)
    );

    // Next-state: accumulate, present, park/drop while stalled, restart on handshake
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        gov_d      = gov_q;
        acc_out_d  = acc_out_q;
        ovf_d      = ovf_q;
        vld_d      = vld_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        drop_d     = 1'b0;

        if (clr) begin
            state_d    = ACC;
            acc_d      = '0;
            cnt_d      = '0;
            gov_d      = 1'b0;
            acc_out_d  = '0;
            ovf_d      = 1'b0;
            vld_d      = 1'b0;
            pend_d     = '0;
            pend_vld_d = 1'b0;
        end else if (state_q == ACC) begin
            if (z_flag) begin
                if (cnt_q == LAST_CNT) begin
                    acc_out_d = sum_acc;
                    ovf_d     = gov_q | ovf_acc;
                    vld_d     = 1'b1;
                    state_d   = HOLD;
                    acc_d     = '0;
                    cnt_d     = '0;
                    gov_d     = 1'b0;
                end else begin
                    acc_d = sum_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    gov_d = gov_q | ovf_acc;
                end
            end
        end else if (acc_ready) begin
            // Handshake: result leaves, parked product then z open the next group
            vld_d      = 1'b0;
            ovf_d      = 1'b0;
            state_d    = ACC;
            pend_vld_d = 1'b0;
            if (pend_vld_q && z_flag) begin
                if (N_TERMS == 1) begin
                    // Parked product alone is a full group; z waits its turn
                    acc_out_d  = pend_ext;
                    vld_d      = 1'b1;
                    state_d    = HOLD;
                    pend_d     = z;
                    pend_vld_d = 1'b1;
                end else if (N_TERMS == 2) begin
                    acc_out_d = sum_new;
                    ovf_d     = ovf_new;
                    vld_d     = 1'b1;
                    state_d   = HOLD;
                end else begin
                    acc_d = sum_new;
                    cnt_d = CNT_W'(2);
                    gov_d = ovf_new;
                end
            end else if (pend_vld_q || z_flag) begin
                if (N_TERMS == 1) begin
                    acc_out_d = one_term;
                    vld_d     = 1'b1;
                    state_d   = HOLD;
                end else begin
                    acc_d = one_term;
                    cnt_d = CNT_W'(1);
                    gov_d = 1'b0;
                end
            end
        end else if (z_flag) begin
            if (!pend_vld_q) begin
                pend_d     = z;
                pend_vld_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            gov_q      <= 1'b0;
            acc_out_q  <= '0;
            ovf_q      <= 1'b0;
            vld_q      <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            gov_q      <= gov_d;
            acc_out_q  <= acc_out_d;
            ovf_q      <= ovf_d;
            vld_q      <= vld_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            drop_q     <= drop_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = vld_q;
    assign ovf       = ovf_q;
    assign drop      = drop_q;
    assign busy      = (cnt_q != '0) || (state_q == HOLD);

endmodule

// File: tb/tb_seq_mul_acc.sv
// Bench: two accumulators (4 terms/20 bits and 2 terms/16 bits) on shared stimulus,
// checked by a queue scoreboard fed from an integer reference model.
// Directed scenarios first, then randomized traffic.
module tb_seq_mul_acc;

    localparam int N0 = 4;
    localparam int W0 = 20;
    localparam int N1 = 2;
    localparam int W1 = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [15:0]   z = '0;
    logic          z_flag = 1'b0;
    logic          acc_ready = 1'b1;

    logic [W0-1:0] acc_out0;
    logic          acc_valid0, ovf0, drop0, busy0;
    logic [W1-1:0] acc_out1;
    logic          acc_valid1, ovf1, drop1, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_mul_acc #(.N_TERMS(N0), .ACC_W(W0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .z(z), .z_flag(z_flag),
        .acc_out(acc_out0), .acc_valid(acc_valid0), .acc_ready(acc_ready),
        .ovf(ovf0), .drop(drop0), .busy(busy0)
    );

    seq_mul_acc #(.N_TERMS(N1), .ACC_W(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .z(z), .z_flag(z_flag),
        .acc_out(acc_out1), .acc_valid(acc_valid1), .acc_ready(acc_ready),
        .ovf(ovf1), .drop(drop1), .busy(busy1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        longint val;
        bit     ovf;
    } res_t;

    res_t   q0[$];
    res_t   q1[$];
    int     m_cnt[2];
    longint m_acc[2];
    bit     m_gov[2];
    bit     m_hold[2];
    bit     m_pv[2];
    int     m_pval[2];
    bit     m_drop[2];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int d);
        m_cnt[d]  = 0;
        m_acc[d]  = 0;
        m_gov[d]  = 0;
        m_hold[d] = 0;
        m_pv[d]   = 0;
        m_pval[d] = 0;
        m_drop[d] = 0;
    endtask

    task automatic push_res(input int d, input longint v, input bit o);
        res_t r;
        r.val = v;
        r.ovf = o;
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic add_term(input int d, input int t);
        int     n;
        int     w;
        longint s, mx, mn;
        n  = (d == 0) ? N0 : N1;
        w  = (d == 0) ? W0 : W1;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s  = m_acc[d] + longint'(t);
        if (s > mx || s < mn) m_gov[d] = 1;
        if (s > mx)      s = s - (longint'(1) <<< w);
        else if (s < mn) s = s + (longint'(1) <<< w);
        m_acc[d] = s;
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] == n) begin
            push_res(d, s, m_gov[d]);
            m_acc[d]  = 0;
            m_cnt[d]  = 0;
            m_gov[d]  = 0;
            m_hold[d] = 1;
        end
    endtask

    // A product either joins the group, waits in the single spare slot, or is lost
    task automatic deliver(input int d, input int t);
        if (m_hold[d]) begin
            if (!m_pv[d]) begin
                m_pv[d]   = 1;
                m_pval[d] = t;
            end else begin
                m_drop[d] = 1;
            end
        end else begin
            add_term(d, t);
        end
    endtask

    task automatic step(input int d);
        int zt;
        zt = int'($signed(z));
        m_drop[d] = 0;
        if (clr) begin
            // A held result accepted this cycle was already taken by the monitor
            if (m_hold[d] && !acc_ready) begin
                if (d == 0 && q0.size() > 0) q0.delete(q0.size() - 1);
                if (d == 1 && q1.size() > 0) q1.delete(q1.size() - 1);
            end
            model_clear(d);
        end else if (m_hold[d] && acc_ready) begin
            m_hold[d] = 0;
            if (m_pv[d]) begin
                m_pv[d] = 0;
                deliver(d, m_pval[d]);
            end
            if (z_flag) deliver(d, zt);
        end else if (z_flag) begin
            deliver(d, zt);
        end
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear(0);
                model_clear(1);
                q0.delete();
                q1.delete();
            end else begin
                step(0);
                step(1);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic mon(input int d, input bit vld, input longint outv, input bit ov,
                       input bit dr, input bit bz);
        res_t r;
        bit   have;
        chk($sformatf("valid%0d", d), longint'(vld), longint'(m_hold[d]));
        if (vld && acc_ready) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                total++;
                bad++;
                $display("FAIL result%0d: got %0d with nothing expected (t=%0t)", d, outv, $time);
            end else begin
                if (d == 0) r = q0.pop_front();
                else        r = q1.pop_front();
                chk($sformatf("result%0d", d), outv, r.val);
                chk($sformatf("ovf%0d", d), longint'(ov), longint'(r.ovf));
            end
        end
        chk($sformatf("drop%0d", d), longint'(dr), longint'(m_drop[d]));
        chk($sformatf("busy%0d", d), longint'(bz), longint'(m_cnt[d] != 0 || m_hold[d]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0, acc_valid0, longint'($signed(acc_out0)), ovf0, drop0, busy0);
                mon(1, acc_valid1, longint'($signed(acc_out1)), ovf1, drop1, busy1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit f, input logic [15:0] v, input bit rdy, input bit c);
        @(posedge clk);
        #1;
        z_flag    = f;
        z         = v;
        acc_ready = rdy;
        clr       = c;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(acc_valid0), 0);
        chk("rst_out", longint'(acc_out0), 0);
        chk("rst_busy", longint'(busy0), 0);
        chk("rst_ovf", longint'(ovf1), 0);
        rst_n = 1'b1;

        // Basic 4-term sum with a negative product
        cyc(1, 16'd3, 1, 0);
        cyc(1, 16'hFFFB, 1, 0);
        cyc(1, 16'd100, 1, 0);
        cyc(1, 16'd2, 1, 0);
        cyc(0, 16'd0, 1, 0);
        chk("sum4_valid", longint'(acc_valid0), 1);
        chk("sum4_out", longint'(acc_out0), 100);
        chk("sum4_ovf", longint'(ovf0), 0);
        cyc(0, 16'd0, 1, 0);
        chk("sum4_valid_drop", longint'(acc_valid0), 0);

        // 16-bit overflow on the 2-term unit, then a clean group
        cyc(1, 16'h7000, 1, 0);
        cyc(1, 16'h7000, 1, 0);
        cyc(1, 16'd1, 1, 0);
        chk("ovf_out", longint'(acc_out1), 'hE000);
        chk("ovf_flag", longint'(ovf1), 1);
        cyc(1, 16'd1, 1, 0);
        cyc(0, 16'd0, 1, 0);
        chk("post_ovf_out", longint'(acc_out1), 2);
        chk("post_ovf_flag", longint'(ovf1), 0);
        chk("big_sum_out", longint'(acc_out0), 57346);

        // Stall: one product parked, the next dropped, parked one opens next group
        repeat (4) cyc(1, 16'd1, 0, 0);
        cyc(1, 16'd7, 0, 0);
        cyc(1, 16'd9, 0, 0);
        cyc(1, 16'd10, 1, 0);
        chk("drop_pulse", longint'(drop0), 1);
        cyc(1, 16'd20, 1, 0);
        chk("drop_once", longint'(drop0), 0);
        cyc(1, 16'd30, 1, 0);
        cyc(0, 16'd0, 1, 0);
        chk("pend_sum_out", longint'(acc_out0), 67);

        // Parked product plus z in the handshake cycle
        repeat (4) cyc(1, 16'd1, 0, 0);
        cyc(1, 16'd4, 0, 0);
        cyc(1, 16'd6, 1, 0);
        cyc(1, 16'd1, 1, 0);
        cyc(1, 16'd1, 1, 0);
        cyc(0, 16'd0, 1, 0);
        chk("hs_combine_out", longint'(acc_out0), 12);
        chk("hs_combine_drop", longint'(drop0), 0);

        // clr mid-group with a coincident product
        cyc(1, 16'd1, 1, 0);
        cyc(1, 16'd1, 1, 0);
        cyc(1, 16'd5, 1, 1);
        cyc(0, 16'd0, 1, 0);
        chk("clr_busy", longint'(busy0), 0);
        cyc(1, 16'd1, 1, 0);
        cyc(1, 16'd2, 1, 0);
        cyc(1, 16'd3, 1, 0);
        cyc(1, 16'd4, 1, 0);
        cyc(0, 16'd0, 1, 0);
        chk("clr_next_out", longint'(acc_out0), 10);

        // Asynchronous reset while holding a result with a parked product
        repeat (4) cyc(1, 16'd1, 0, 0);
        cyc(1, 16'd2, 0, 0);
        cyc(0, 16'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", longint'(acc_valid0), 0);
        chk("arst_out", longint'(acc_out0), 0);
        chk("arst_ovf", longint'(ovf0), 0);
        chk("arst_busy", longint'(busy0), 0);
        chk("arst_valid1", longint'(acc_valid1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 16'd5, 1, 0);
        cyc(1, 16'd6, 1, 0);
        cyc(1, 16'd7, 1, 0);
        cyc(1, 16'd8, 1, 0);
        cyc(0, 16'd0, 1, 0);
        chk("arst_next_out", longint'(acc_out0), 26);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
        end

        // Drain
        repeat (6) cyc(0, 16'd0, 1, 0);
        chk("q0_empty", longint'(q0.size()), 0);
        chk("q1_empty", longint'(q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
